// File: rtl/siso_shift_reg_pkg.sv
// Shared constants for the shift-register library.
//   SISO_DEFAULT_DEPTH : default stage count for siso_shift_reg
//   SISO_MIN_DEPTH / SISO_MAX_DEPTH : legal DEPTH range
//   SHIFT_RESET_VALUE  : default value loaded into every stage on reset
package shift_reg_pkg;

  localparam int unsigned SISO_DEFAULT_DEPTH = 4;
  localparam int unsigned SISO_MIN_DEPTH     = 1;
  localparam int unsigned SISO_MAX_DEPTH     = 64;
  localparam logic        SHIFT_RESET_VALUE  = 1'b0;

endpackage : shift_reg_pkg

// File: rtl/siso_shift_reg_if.sv
// Serial data interface for siso_shift_reg.
//   serial_in  : serial data into the register (driven by master)
//   serial_out : serial data out of the last stage (driven by slave)
interface siso_shift_reg_if;

  logic serial_in;
  logic serial_out;

  modport master (
    output serial_in,
    input  serial_out
  );

  modport slave (
    input  serial_in,
    output serial_out
  );

endinterface : siso_shift_reg_if

// File: rtl/siso_shift_reg_stage.sv
// siso_stage: one register stage, a D flip-flop with asynchronous
// active-high reset to RESET_VALUE.
//   clk : rising-edge clock
//   rst : asynchronous reset, active-high
//   d   : stage input
//   q   : stage output
module siso_stage
  import shift_reg_pkg::*;
#(
  parameter logic RESET_VALUE = SHIFT_RESET_VALUE
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule : siso_stage

// File: rtl/siso_shift_reg.sv
// siso_shift_reg: serial-in, serial-out shift register of DEPTH stages.
// A bit captured on a rising edge leaves on serial_out DEPTH edges later
// (counting the capture edge). Output is registered.
//   clk              : rising-edge clock
//   rst              : asynchronous reset, active-high
//   bus.serial_in    : serial data in, sampled every rising edge
//   bus.serial_out   : serial data out, driven by the last stage
// Parameters:
//   DEPTH       : number of stages, 1..64
//   RESET_VALUE : value loaded into every stage on reset
module siso_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int unsigned DEPTH       = SISO_DEFAULT_DEPTH,
  parameter logic        RESET_VALUE = SHIFT_RESET_VALUE
) (
  input  logic             clk,
  input  logic             rst,
  siso_shift_reg_if.slave  bus
);

  logic [DEPTH-1:0] stage;

  // Stage 0 is fed from serial_in; every later stage from its predecessor.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      siso_stage #(
        .RESET_VALUE (RESET_VALUE)
      ) u_stage (
        .clk (clk),
        .rst (rst),
        .d   (bus.serial_in),
        .q   (stage[i])
      );
    end else begin : g_chain
      siso_stage #(
        .RESET_VALUE (RESET_VALUE)
      ) u_stage (
        .clk (clk),
        .rst (rst),
        .d   (stage[i-1]),
        .q   (stage[i])
      );
    end
  end

  assign bus.serial_out = stage[DEPTH-1];

endmodule : siso_shift_reg

// File: tb/tb_siso_shift_reg.sv
// Testbench for siso_shift_reg: DEPTH=1, 4 and 8 instances driven with the
// same serial stream; table-driven vectors plus hand-written sequences.
module tb_siso_shift_reg;

  logic clk = 1'b0;
  logic rst;
  logic din;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  // Reference history: bit 0 is the most recently captured bit.
  logic [63:0] hist;

  always #5 clk = ~clk;

  siso_shift_reg_if if1 ();
  siso_shift_reg_if if4 ();
  siso_shift_reg_if if8 ();

  assign if1.serial_in = din;
  assign if4.serial_in = din;
  assign if8.serial_in = din;

  siso_shift_reg #(.DEPTH(1), .RESET_VALUE(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  siso_shift_reg #(.DEPTH(4), .RESET_VALUE(1'b0)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  siso_shift_reg #(.DEPTH(8), .RESET_VALUE(1'b0)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  typedef struct {
    logic in_bit;
    logic exp1;
    logic exp4;
    logic exp8;
  } vec_t;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check(input string tag);
    check({tag, " d1"}, if1.serial_out, hist[0]);
    check({tag, " d4"}, if4.serial_out, hist[3]);
    check({tag, " d8"}, if8.serial_out, hist[7]);
  endtask

  // Called at a falling edge; drives one bit, checks just after the rising
  // edge, returns at the next falling edge.
  task automatic step(input logic b, input string tag);
    din = b;
    @(posedge clk);
    if (!rst) hist = {hist[62:0], b};
    #1;
    model_check(tag);
    @(negedge clk);
  endtask

  // Called at a falling edge; pulses reset over one rising edge.
  task automatic do_reset();
    rst  = 1'b1;
    hist = '0;
    #1;
    model_check("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[8];
    logic        sb[$];
    logic        exp_bit;
    logic [31:0] rnd;

    // Edges 15..85 ns: input 1,0,1,1 then held 1.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

    rst  = 1'b1;
    din  = 1'b0;
    hist = '0;

    #1;
    check("por d4", if4.serial_out, 1'b0);
    check("por d1", if1.serial_out, 1'b0);
    check("por d8", if8.serial_out, 1'b0);
    @(posedge clk);
    #1;
    check("rst edge d4", if4.serial_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].in_bit, "tbl model");
      check($sformatf("tbl[%0d] d1", i), if1.serial_out, tbl[i].exp1);
      check($sformatf("tbl[%0d] d4", i), if4.serial_out, tbl[i].exp4);
      check($sformatf("tbl[%0d] d8", i), if8.serial_out, tbl[i].exp8);
    end

    // Asynchronous reset mid-period while d4 holds 1011 (front bit = 1).
    do_reset();
    step(1'b1, "load");
    step(1'b0, "load");
    step(1'b1, "load");
    step(1'b1, "load");
    check("pre-async d4", if4.serial_out, 1'b1);
    #2;
    rst  = 1'b1;
    hist = '0;
    #1;
    check("async d4", if4.serial_out, 1'b0);
    check("async d1", if1.serial_out, 1'b0);
    @(negedge clk);
    check("rst over edge d4", if4.serial_out, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, "post-async");
      check($sformatf("post-async edge%0d d4", k), if4.serial_out, (k == 3) ? 1'b1 : 1'b0);
    end

    // Walking single 1.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step((k == 0) ? 1'b1 : 1'b0, "walk");
      check($sformatf("walk edge%0d d4", k), if4.serial_out, (k == 3) ? 1'b1 : 1'b0);
    end

    // Alternating stream against a scoreboard queue.
    do_reset();
    sb = '{1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 16; k++) begin
      exp_bit = (k % 2 == 0) ? 1'b1 : 1'b0;
      sb.push_back(exp_bit);
      step(exp_bit, "alt");
      check($sformatf("alt edge%0d d4", k), if4.serial_out, sb.pop_front());
    end

    // Random 32-bit stream for all depths, then a zero flush.
    do_reset();
    rnd = $urandom;
    for (int k = 0; k < 32; k++) begin
      step(rnd[k], $sformatf("rnd edge%0d", k));
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, $sformatf("flush edge%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_siso_shift_reg
